// File: rtl/io_toggle_checker.sv
// io_toggle_checker: receive-side checker for the board I/O toggle loopback test.
// Define IO_TOGGLE_CHECK_ERRMASK_EN to build the per-pin err_mask; otherwise err_mask is tied to 0.
module io_toggle_checker #(
  parameter int WIDTH         = 54,
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT_BITS  = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] io_1,
  input  logic [WIDTH-1:0] io_2,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [15:0]      toggle_count,
  output logic [WIDTH-1:0] err_mask,
  output logic             led_ok,
  output logic             led_err
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] STAB_PRE = SW'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  typedef enum logic {ST_ACQ, ST_LOCK} state_t;

  state_t                  r_state, w_next;
  logic [WIDTH-1:0]        r_m1, r_m2, r_s1, r_s2, r_p1, r_p2;
  logic [SW-1:0]           r_stab;
  logic [TIMEOUT_BITS-1:0] r_wd;
  logic [15:0]             r_cnt;
  logic                    r_exp;   // 1: next expected phase is PH_HI
  logic                    r_err;

  logic w_change, w_settled, w_hi, w_lo, w_valid;
  logic w_lock_set, w_accept, w_bad, w_wd_fire;

  // Two-flop synchronizer plus a one-sample history for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m1 <= '0;
      r_m2 <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_p1 <= '0;
      r_p2 <= '0;
    end else begin
      r_m1 <= io_1;
      r_m2 <= io_2;
      r_s1 <= r_m1;
      r_s2 <= r_m2;
      r_p1 <= r_s1;
      r_p2 <= r_s2;
    end
  end

  assign w_change = (r_s1 != r_p1) || (r_s2 != r_p2);
  assign w_hi     = (&r_s1) && !(|r_s2);
  assign w_lo     = !(|r_s1) && (&r_s2);
  assign w_valid  = w_hi || w_lo;

  // Event is raised in the cycle whose edge moves the counter onto SETTLE_CYCLES.
  assign w_settled = !clear && !w_change && (r_stab == STAB_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_stab <= '0;
    else if (clear || w_change)  r_stab <= '0;
    else if (r_stab != STAB_MAX) r_stab <= r_stab + 1'b1;
  end

  assign w_wd_fire = (r_state == ST_LOCK) && (r_wd == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ACQ;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_lock_set = 1'b0;
    w_accept   = 1'b0;
    w_bad      = 1'b0;
    case (r_state)
      ST_ACQ: begin
        if (w_settled && w_valid) begin
          w_next     = ST_LOCK;
          w_lock_set = 1'b1;
        end
      end
      ST_LOCK: begin
        if (w_settled) begin
          if (r_exp ? w_hi : w_lo) w_accept = 1'b1;
          else if (!w_valid)       w_bad    = 1'b1;
        end
      end
      default: w_next = ST_ACQ;
    endcase
    if (clear) w_next = ST_ACQ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_exp <= 1'b0;
    else if (w_lock_set) r_exp <= w_lo;
    else if (w_accept)   r_exp <= ~r_exp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_cnt <= '0;
    else if (clear)                     r_cnt <= '0;
    else if (w_accept && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  end

  // Watchdog wraps to 0 when it fires so a stalled link keeps re-flagging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_wd <= '0;
    else if (clear || r_state != ST_LOCK)      r_wd <= '0;
    else if (w_accept || w_wd_fire)            r_wd <= '0;
    else                                       r_wd <= r_wd + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_err <= 1'b0;
    else if (clear)              r_err <= 1'b0;
    else if (w_bad || w_wd_fire) r_err <= 1'b1;
  end

`ifdef IO_TOGGLE_CHECK_ERRMASK_EN
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] w_pin_err;

  // Blame pins that miss the phase the pattern generator was moving to.
  assign w_pin_err = r_exp ? (~r_s1 | r_s2) : (r_s1 | ~r_s2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_mask <= '0;
    else if (clear) r_mask <= '0;
    else if (w_bad) r_mask <= r_mask | w_pin_err;
  end

  assign err_mask = r_mask;
`else
  assign err_mask = '0;
`endif

  assign locked       = (r_state == ST_LOCK);
  assign err          = r_err;
  assign toggle_count = r_cnt;
  assign led_ok       = locked & ~r_err;
  assign led_err      = r_err;

endmodule
